// File: rtl/digit_scan_framer.sv
// -----------------------------------------------------------------------------
// digit_scan_framer
//
// Purpose:
//   Time-multiplexes NUM_DIGITS hex digits onto a shift-register display
//   driver. A free-running scan counter produces one tick every
//   2^SCAN_DIV_BITS cycles. Each tick presents one 16-bit frame
//   {one-hot digit select, segment byte} with a valid/ready handshake.
//   A shadow register captures new values at any time. The shadow is copied
//   into the displayed (active) value only when digit 0 is presented, so a
//   number is never shown half old and half new.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed hex digits (1..4)
//   SCAN_DIV_BITS  scan tick period is 2^SCAN_DIV_BITS cycles (2..24)
//
// Build option:
//   DIGIT_SCAN_BLANK_EN  when defined, leading-zero digits above the highest
//                        nonzero digit show segment byte 8'h00. Digit 0 is
//                        never blanked.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_value        value to display, digit 0 in [3:0]
//   i_value_load   one-cycle strobe, captures i_value into the shadow
//   i_frame_ready  downstream serializer accepts the presented frame
//   o_frame        [15:8] one-hot digit select, [7:0] segment byte
//   o_frame_valid  o_frame is presented
//   o_digit_index  digit index carried by o_frame
//   o_overrun      sticky: a scan tick arrived while a frame was still pending
// -----------------------------------------------------------------------------
module digit_scan_framer #(
  parameter int NUM_DIGITS    = 3,
  parameter int SCAN_DIV_BITS = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_value_load,
  input  logic                    i_frame_ready,
  output logic [15:0]             o_frame,
  output logic                    o_frame_valid,
  output logic [1:0]              o_digit_index,
  output logic                    o_overrun
);

  localparam int         VALUE_W    = 4 * NUM_DIGITS;
  localparam logic [1:0] LAST_INDEX = 2'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_WAIT_TICK,
    ST_PRESENT
  } state_t;

  // Segment bit order is {dp, g, f, e, d, c, b, a}, active high, dp unused.
  function automatic logic [7:0] hex_to_7seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'h3F;
      4'h1:    seg = 8'h06;
      4'h2:    seg = 8'h5B;
      4'h3:    seg = 8'h4F;
      4'h4:    seg = 8'h66;
      4'h5:    seg = 8'h6D;
      4'h6:    seg = 8'h7D;
      4'h7:    seg = 8'h07;
      4'h8:    seg = 8'h7F;
      4'h9:    seg = 8'h6F;
      4'hA:    seg = 8'h77;
      4'hB:    seg = 8'h7C;
      4'hC:    seg = 8'h39;
      4'hD:    seg = 8'h5E;
      4'hE:    seg = 8'h79;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

  logic [SCAN_DIV_BITS-1:0] r_scan_cnt;
  state_t                   r_state;
  logic [VALUE_W-1:0]       r_shadow;
  logic [VALUE_W-1:0]       r_active;
  logic [1:0]               r_index;
  logic [15:0]              r_frame;
  logic                     r_frame_valid;
  logic                     r_overrun;

  logic                     w_tick;
  logic                     w_new_overrun;
  logic [VALUE_W-1:0]       w_src_value;
  logic [15:0]              w_src_pad;
  logic [3:0]               w_nibble;
  logic [7:0]               w_sel;
  logic [7:0]               w_seg_dec;
  logic [7:0]               w_seg;

  assign w_tick        = &r_scan_cnt;
  assign w_new_overrun = (r_state == ST_PRESENT) && w_tick;

  // A frame for digit 0 is built in the same cycle that the shadow becomes
  // the active value. The decoder therefore reads the shadow at index 0 and
  // the active value at every other index. A load that lands on the commit
  // edge updates the shadow only after this read, so it waits a full scan.
  assign w_src_value = (r_index == 2'd0) ? r_shadow : r_active;
  assign w_src_pad   = 16'(w_src_value);
  assign w_nibble    = w_src_pad[{r_index, 2'b00} +: 4];
  assign w_sel       = 8'h01 << r_index;

  // One decoder serves every digit; only its input nibble is multiplexed.
  assign w_seg_dec = hex_to_7seg(w_nibble);

`ifdef DIGIT_SCAN_BLANK_EN
  logic w_blank;
  // A digit is a leading zero when it and every digit above it are zero.
  assign w_blank = (r_index != 2'd0) &&
                   ((w_src_pad >> {r_index, 2'b00}) == 16'h0000);
  assign w_seg   = w_blank ? 8'h00 : w_seg_dec;
`else
  assign w_seg = w_seg_dec;
`endif

  // NOTE: clocked state uses non-blocking assignments so that every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_scan_cnt <= '0;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_DIV_BITS'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shadow <= '0;
    end else if (i_value_load) begin
      r_shadow <= i_value;
    end
  end

  // A load clears the sticky flag. A tick missed in the same cycle sets it
  // again, and that takes priority.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_new_overrun | (r_overrun & ~i_value_load);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_WAIT_TICK;
      r_frame       <= 16'h0000;
      r_frame_valid <= 1'b0;
      r_index       <= 2'd0;
      r_active      <= '0;
    end else begin
      case (r_state)
        ST_WAIT_TICK: begin
          if (w_tick) begin
            r_state       <= ST_PRESENT;
            r_frame_valid <= 1'b1;
            r_frame       <= {w_sel, w_seg};
            if (r_index == 2'd0) begin
              r_active <= r_shadow;
            end
          end
        end
        ST_PRESENT: begin
          // The frame and index are held here until the serializer accepts.
          // Ticks seen in this state only raise the overrun flag.
          if (i_frame_ready) begin
            r_state       <= ST_WAIT_TICK;
            r_frame_valid <= 1'b0;
            r_index       <= (r_index == LAST_INDEX) ? 2'd0 : r_index + 2'd1;
          end
        end
        default: begin
          r_state <= ST_WAIT_TICK;
        end
      endcase
    end
  end

  assign o_frame       = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_digit_index = r_index;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_digit_scan_framer.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_framer
//
// Self-checking bench for digit_scan_framer with NUM_DIGITS=3 and
// SCAN_DIV_BITS=2. Directed scenarios use hand-derived literal frames. The
// randomized phase compares every cycle against a behavioural model. The model
// tracks elapsed cycles since reset, the digit being shown, the shadow and
// displayed numbers, and whether a frame is pending. It computes each frame
// with plain arithmetic from those values.
// Define DIGIT_SCAN_BLANK_EN for both RTL and bench to exercise blanking.
// -----------------------------------------------------------------------------
module tb_digit_scan_framer;

  localparam int NUM_DIGITS    = 3;
  localparam int SCAN_DIV_BITS = 2;
  localparam int PERIOD        = 1 << SCAN_DIV_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] value = '0;
  logic        load = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] frame;
  logic        valid;
  logic [1:0]  idx;
  logic        ovr;

  int n_checks = 0;
  int n_fail   = 0;

  digit_scan_framer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SCAN_DIV_BITS(SCAN_DIV_BITS)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_value      (value),
    .i_value_load (load),
    .i_frame_ready(ready),
    .o_frame      (frame),
    .o_frame_valid(valid),
    .o_digit_index(idx),
    .o_overrun    (ovr)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] seg_lut [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                               8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C,
                               8'h39, 8'h5E, 8'h79, 8'h71};

  int unsigned m_cnt    = 0;  // cycles since reset, modulo the scan period
  int unsigned m_idx    = 0;
  int unsigned m_active = 0;
  int unsigned m_shadow = 0;
  bit          m_valid  = 1'b0;
  bit          m_ovr    = 1'b0;
  bit          m_tick;
  bit          m_pending;
  logic [15:0] m_frame  = 16'h0000;

  function automatic logic [7:0] exp_seg(int unsigned val, int unsigned d);
`ifdef DIGIT_SCAN_BLANK_EN
    if (d != 0 && (val >> (4 * d)) == 0) return 8'h00;
`endif
    return seg_lut[(val >> (4 * d)) & 15];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_active = 0; m_shadow = 0;
      m_valid = 1'b0; m_ovr = 1'b0; m_frame = 16'h0000;
    end else begin
      m_tick    = (m_cnt == PERIOD - 1);
      m_pending = m_valid;
      if (!m_valid && m_tick) begin
        if (m_idx == 0) m_active = m_shadow;
        m_valid = 1'b1;
        m_frame = {8'(1 << m_idx), exp_seg(m_active, m_idx)};
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
        m_idx   = (m_idx + 1) % NUM_DIGITS;
      end
      m_ovr = (m_pending && m_tick) || (m_ovr && !load);
      if (load) m_shadow = value;
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  // ---------------------------------------------------------------------------
  // Stepping helper: advance to the next negedge showing a valid frame
  // ---------------------------------------------------------------------------
  task automatic wait_frame(output int waited);
    waited = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        waited = k;
        break;
      end
    end
    n_checks++;
    if (waited < 0) begin
      n_fail++;
      $display("FAIL wait_frame timeout got=no_valid need=valid within 40 cycles");
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int k_valid;
    rst = 1'b1; load = 1'b0; ready = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b need=0", valid); end
    n_checks++;
    if (frame !== 16'h0000) begin n_fail++; $display("FAIL reset_frame got=%h need=0000", frame); end
    n_checks++;
    if (idx !== 2'd0) begin n_fail++; $display("FAIL reset_index got=%0d need=0", idx); end
    n_checks++;
    if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b need=0", ovr); end

    rst = 1'b0; value = 12'h321; load = 1'b1; ready = 1'b1;
    k_valid = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (valid === 1'b1) begin
        k_valid = k;
        break;
      end
    end
    n_checks++;
    if (k_valid != PERIOD) begin
      n_fail++; $display("FAIL first_frame_latency got=%0d need=%0d", k_valid, PERIOD);
    end
    n_checks++;
    if (frame !== 16'h0106) begin n_fail++; $display("FAIL first_frame got=%h need=0106", frame); end
  endtask

  task automatic test_scan_order();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h025B; exp_seq[1] = 16'h044F;
    exp_seq[2] = 16'h0106; exp_seq[3] = 16'h025B;
    for (int j = 0; j < 4; j++) begin
      for (int k = 1; k <= PERIOD; k++) begin
        @(negedge clk);
        if (k < PERIOD) begin
          n_checks++;
          if (valid !== 1'b0) begin
            n_fail++; $display("FAIL scan_gap frame=%0d cyc=%0d got=%b need=0", j, k, valid);
          end
        end
      end
      n_checks++;
      if (valid !== 1'b1 || frame !== exp_seq[j]) begin
        n_fail++;
        $display("FAIL scan_order frame=%0d got=%b/%h need=1/%h", j, valid, frame, exp_seq[j]);
      end
    end
    n_checks++;
    if (ovr !== 1'b0) begin n_fail++; $display("FAIL scan_no_overrun got=%b need=0", ovr); end
  endtask

  task automatic test_backpressure_overrun();
    // Entry: the digit 1 frame 16'h025B is being presented.
    ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b1 || frame !== 16'h025B || idx !== 2'd1) begin
        n_fail++;
        $display("FAIL hold_stable cyc=%0d got=%b/%h/%0d need=1/025B/1", k, valid, frame, idx);
      end
    end
    n_checks++;
    if (ovr !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%b need=1", ovr); end
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || idx !== 2'd2) begin
      n_fail++; $display("FAIL handshake_release got=%b/%0d need=0/2", valid, idx);
    end
    n_checks++;
    if (ovr !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got=%b need=1", ovr); end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (ovr !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got=%b need=0", ovr); end
  endtask

  task automatic test_load_mid_scan();
    int w;
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h044F; exp_seq[1] = 16'h0139;
    exp_seq[2] = 16'h027C; exp_seq[3] = 16'h0477;
    ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_frame(w);
      if (idx === 2'd1) break;
    end
    n_checks++;
    if (valid !== 1'b1 || idx !== 2'd1) begin
      n_fail++; $display("FAIL find_digit1 got=%b/%0d need=1/1", valid, idx);
    end
    value = 12'hABC; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wait_frame(w);
      n_checks++;
      if (frame !== exp_seq[j]) begin
        n_fail++; $display("FAIL load_mid_scan frame=%0d got=%h need=%h", j, frame, exp_seq[j]);
      end
    end
  endtask

  task automatic test_reset_mid_present();
    int w;
    int k_valid;
    ready = 1'b0;
    wait_frame(w);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (valid !== 1'b0 || frame !== 16'h0000 || idx !== 2'd0) begin
      n_fail++; $display("FAIL async_reset got=%b/%h/%0d need=0/0000/0", valid, frame, idx);
    end
    @(negedge clk);
    rst = 1'b0; ready = 1'b1;
    k_valid = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        k_valid = k;
        break;
      end
    end
    n_checks++;
    if (k_valid != PERIOD || frame !== 16'h013F) begin
      n_fail++;
      $display("FAIL post_reset_frame got=%0d/%h need=%0d/013F", k_valid, frame, PERIOD);
    end
  endtask

`ifdef DIGIT_SCAN_BLANK_EN
  task automatic test_blank();
    int w;
    logic [15:0] exp_seq [5];
    exp_seq[0] = 16'h016D; exp_seq[1] = 16'h0200; exp_seq[2] = 16'h0400;
    exp_seq[3] = 16'h013F; exp_seq[4] = 16'h0200;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; value = 12'h005; load = 1'b1; ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wait_frame(w);
      n_checks++;
      if (frame !== exp_seq[j]) begin
        n_fail++; $display("FAIL blank frame=%0d got=%h need=%h", j, frame, exp_seq[j]);
      end
      if (j == 2) begin
        value = 12'h000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b need=%b", c, valid, m_valid);
      end
      n_checks++;
      if (idx !== 2'(m_idx)) begin
        n_fail++; $display("FAIL rnd_index cyc=%0d got=%0d need=%0d", c, idx, m_idx);
      end
      n_checks++;
      if (ovr !== m_ovr) begin
        n_fail++; $display("FAIL rnd_overrun cyc=%0d got=%b need=%b", c, ovr, m_ovr);
      end
      n_checks++;
      if (frame !== m_frame) begin
        n_fail++; $display("FAIL rnd_frame cyc=%0d got=%h need=%h", c, frame, m_frame);
      end
      if (rst) rst = 1'b0;
      else     rst = ($urandom_range(0, 199) == 0);
      value = 12'($urandom);
      load  = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_backpressure_overrun();
    test_load_mid_scan();
    test_reset_mid_present();
`ifdef DIGIT_SCAN_BLANK_EN
    test_blank();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_scan_framer.md
DIGIT_SCAN_FRAMER -- requirements
Module: digit_scan_framer

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 3, giving the number of multiplexed hex digits (legal 1..4).
REQ-002 The block SHALL have parameter SCAN_DIV_BITS, default 6, giving the scan tick period of 2^SCAN_DIV_BITS clock cycles (legal 2..24).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_value, input, 4*NUM_DIGITS bits: the hex value to display, with digit 0 in bits [3:0].
REQ-006 The block SHALL have port i_value_load, input, 1 bit: a one-cycle strobe that captures i_value into the shadow register.
REQ-007 The block SHALL have port i_frame_ready, input, 1 bit: the downstream shift-register serializer accepts the frame.
REQ-008 The block SHALL have port o_frame, output, 16 bits: [15:8] is the one-hot digit select and [7:0] is the segment byte.
REQ-009 The block SHALL have port o_frame_valid, output, 1 bit: o_frame is presented.
REQ-010 The block SHALL have port o_digit_index, output, 2 bits: the index of the digit in o_frame.
REQ-011 The block SHALL have port o_overrun, output, 1 bit: a sticky flag indicating a scan tick was missed.

Function
REQ-012 A free-running SCAN_DIV_BITS-bit counter SHALL generate a one-cycle tick when it is all-ones.
REQ-013 The FSM SHALL have two states, WAIT_TICK and PRESENT.
REQ-014 In WAIT_TICK, a tick SHALL cause a move to PRESENT on the next edge, with o_frame loaded and o_frame_valid=1, giving 1 cycle of latency.
REQ-015 In PRESENT, o_frame and o_digit_index SHALL stay stable until the cycle where o_frame_valid && i_frame_ready is true.
REQ-016 That handshake cycle SHALL return the FSM to WAIT_TICK, clear valid, and advance the index, wrapping from NUM_DIGITS-1 to 0.
REQ-017 o_frame[15:8] SHALL equal 8'h01 << index, and o_frame[7:0] SHALL equal the output of the codebase hex-to-7seg decoder for the active-value nibble at that index.
REQ-018 The hex-to-7seg decoder SHALL be instantiated once, not duplicated.
REQ-019 The active value SHALL take the shadow value only on a WAIT_TICK-to-PRESENT transition with index 0, so no torn numbers are ever displayed.
REQ-020 When i_value_load coincides with a commit transition, the commit SHALL use the previous shadow value, and the new value SHALL take effect on the next scan cycle.
REQ-021 A tick arriving while in PRESENT SHALL set o_overrun and be otherwise ignored (no queuing).
REQ-022 o_overrun SHALL clear on i_value_load, unless a new overrun occurs in the same cycle, in which case it stays set.
REQ-023 i_frame_ready asserted while o_frame_valid=0 SHALL have no effect.

Reset
REQ-024 While i_reset=1, the block SHALL force asynchronously: o_frame_valid=0, o_frame=16'h0000, o_digit_index=0, o_overrun=0, shadow=0, active value=0, tick counter=0, state WAIT_TICK.
REQ-025 A reset asserted in PRESENT SHALL drop o_frame_valid within the same cycle, without waiting for the handshake.
REQ-026 After reset release, the first tick SHALL occur 2^SCAN_DIV_BITS-1 cycles later.

Configuration
REQ-027 With macro DIGIT_SCAN_BLANK_EN defined, leading-zero digits above the highest nonzero digit SHALL output segment byte 8'h00, and digit 0 SHALL never be blanked.
REQ-028 Without DIGIT_SCAN_BLANK_EN, every digit SHALL always be decoded, and no blanking logic SHALL be compiled.

Verification (SCAN_DIV_BITS=2, NUM_DIGITS=3)
REQ-029 Reset release, load 12'h321, i_frame_ready=1 -> valid frames in order: sel 8'h01 with seg=dec(1), sel 8'h02 with seg=dec(2), sel 8'h04 with seg=dec(3), then wrap to 8'h01, one frame every 4 cycles.
REQ-030 Hold i_frame_ready=0 for 10 cycles during PRESENT -> o_frame stable, o_overrun=1; a later i_value_load pulse -> o_overrun=0.
REQ-031 Load 12'hABC during the digit 1 frame -> digits 1 and 2 still show the old value, and 12'hABC appears starting at the next digit 0.
REQ-032 Assert i_reset mid-PRESENT -> o_frame_valid=0 and o_frame=16'h0000 immediately; after release the first frame is sel 8'h01 from active value 0.
REQ-033 With DIGIT_SCAN_BLANK_EN, load 12'h005 -> segment bytes 8'h00 for digits 2 and 1 and dec(5) for digit 0; load 12'h000 -> digit 0 shows dec(0).
